stack_mem_ctrl: RTL and testbench
=================================

STACK_MEM_CTRL -- requirements
Module: stack_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, data-memory address width.
REQ-002 Parameter DATA_W, default 16, data-memory word width.
REQ-003 Parameter SP_INIT, default 12'hFFF, stack-pointer reset value.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  EX/MEM op presented; in_ready  output  1  op accepted when in_valid & in_ready.
REQ-007 op_load, op_store, op_push, op_pop, op_call, op_ret, op_int, op_rti  input  1 each  op type flags.
REQ-008 alu_addr  input  ADDR_W  load/store address; st_data  input  DATA_W  store/push data; pc_in  input  32  return PC; ccr_in  input  3  flags; rd_in  input  3  dest reg.
REQ-009 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_we  output  1; mem_rdata  input  DATA_W  (combinational read, synchronous write).
REQ-010 wb_valid  output  1; wb_data  output  DATA_W; wb_rd  output  3  registered MEM/WB result.
REQ-011 pc_load  output  1; pc_out  output  32; ccr_load  output  1; ccr_out  output  3; sp_out  output  ADDR_W; stack_err  output  1.

Function
REQ-012 Op priority when several flags set: int > rti > ret > call > pop > push > load > store; no flag = bubble.
REQ-013 Stack grows down: push writes mem[SP] then SP<=SP-1; pop reads mem[SP+1] then SP<=SP+1; SP arithmetic modulo 2^ADDR_W.
REQ-014 FSM states: IDLE, PUSH_LO, PUSH_CCR, POP_2, POP_3.
REQ-015 in_ready = 1 only in IDLE.
REQ-016 Load/store/push/pop complete in acceptance cycle; load/pop assert wb_valid, wb_data=read word, wb_rd=rd_in next cycle.
REQ-017 CALL: cycle 1 pushes pc_in[31:16], -> PUSH_LO; cycle 2 pushes latched pc[15:0], -> IDLE.
REQ-018 INT: pushes pc[31:16], pc[15:0], ccr (zero-extended) in 3 consecutive cycles via PUSH_LO, PUSH_CCR.
REQ-019 RET: pops low half then high half (IDLE->POP_2->IDLE); pc_load=1 for one cycle after final pop with pc_out={high,low}.
REQ-020 RTI: pops ccr, low, high (IDLE->POP_2->POP_3->IDLE); ccr_load and pc_load pulse together one cycle after final pop.
REQ-021 pc_in and ccr_in latched at acceptance; later input changes ignored during sequence.
REQ-022 mem_we only in cycles performing a store or push; mem_addr=alu_addr for load/store, SP-derived otherwise.
REQ-023 wb_valid, pc_load, ccr_load are single-cycle pulses; sp_out reflects current SP.
REQ-024 SP wrap: push at SP=0 writes mem[0], SP becomes 12'hFFF; pop at SP=12'hFFF reads mem[0], SP becomes 0.

Reset
REQ-025 rst low: FSM->IDLE, SP->SP_INIT, all outputs 0 except in_ready=1 and sp_out=SP_INIT, latched PC/CCR cleared.
REQ-026 Reset mid-sequence aborts it; already-written words not undone; no pc_load/ccr_load emitted.

Configuration
REQ-027 Macro STACK_GUARD_EN defined: push at SP=0 or pop at SP=SP_INIT sets sticky stack_err, suppresses mem_we and SP update, sequence still completes in normal cycle count.
REQ-028 STACK_GUARD_EN undefined: REQ-024 wrap applies, stack_err tied 0.

Structure
REQ-029 Shared package holds FSM state enum, op-priority encoding, ADDR_W/DATA_W defaults and SP_INIT.
REQ-030 One sub-module, sp_unit: SP register with inc/dec/hold and guard logic.

Verification
REQ-031 Reset then push 16'hABCD -> mem[12'hFFF]=16'hABCD, sp_out=12'hFFE.
REQ-032 CALL pc_in=32'h0001_0203 at SP=12'hFFF -> mem[FFF]=16'h0001, mem[FFE]=16'h0203, SP=12'hFFD, in_ready low 1 cycle; then RET -> pc_load with pc_out=32'h0001_0203, SP=12'hFFF.
REQ-033 INT pc_in=32'h0000_0050, ccr_in=3'b101 then RTI -> ccr_out=3'b101, pc_out=32'h0000_0050, both loads same cycle, in_ready low 2 cycles each.
REQ-034 op_int and op_load both set -> INT sequence only, no wb_valid.
REQ-035 Store 16'h1234 to 12'h010 then load 12'h010, rd_in=3 -> next cycle wb_valid=1, wb_data=16'h1234, wb_rd=3.
REQ-036 rst low during PUSH_LO of CALL -> IDLE, SP=12'hFFF, no further mem_we; with STACK_GUARD_EN, pop from reset -> stack_err=1, SP unchanged.

Source files
------------

// File: rtl/stack_mem_ctrl_pkg.sv
// stack_mem_ctrl_pkg -- shared types and defaults for the stack/memory controller.
// This package holds the FSM state enum, the op-priority encoding and the size defaults.
package stack_mem_ctrl_pkg;

   localparam int          ADDR_W_DEF  = 12;
   localparam int          DATA_W_DEF  = 16;
   localparam logic [11:0] SP_INIT_DEF = 12'hFFF;

   // Controller sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PUSH_LO  = 3'd1,
      ST_PUSH_CCR = 3'd2,
      ST_POP_2    = 3'd3,
      ST_POP_3    = 3'd4
   } state_e;

   // Decoded operation, listed from highest to lowest priority.
   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_INT   = 4'd1,
      OP_RTI   = 4'd2,
      OP_RET   = 4'd3,
      OP_CALL  = 4'd4,
      OP_POP   = 4'd5,
      OP_PUSH  = 4'd6,
      OP_LOAD  = 4'd7,
      OP_STORE = 4'd8
   } op_e;

   // Resolve several simultaneous op flags to the single highest-priority op.
   function automatic op_e decode_op(
      input logic f_int,
      input logic f_rti,
      input logic f_ret,
      input logic f_call,
      input logic f_pop,
      input logic f_push,
      input logic f_load,
      input logic f_store
   );
      op_e op;
      if      (f_int)   op = OP_INT;
      else if (f_rti)   op = OP_RTI;
      else if (f_ret)   op = OP_RET;
      else if (f_call)  op = OP_CALL;
      else if (f_pop)   op = OP_POP;
      else if (f_push)  op = OP_PUSH;
      else if (f_load)  op = OP_LOAD;
      else if (f_store) op = OP_STORE;
      else              op = OP_NONE;
      return op;
   endfunction

endpackage

// File: rtl/stack_mem_ctrl_sp_unit.sv
// stack_mem_ctrl_sp_unit -- stack pointer register with decrement (push),
// increment (pop) and hold. Optional macro STACK_GUARD_EN blocks a push at
// SP=0 or a pop at SP=SP_INIT and raises a sticky error instead of wrapping.
module stack_mem_ctrl_sp_unit
   import stack_mem_ctrl_pkg::*;
#(
   parameter int                ADDR_W  = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] SP_INIT = SP_INIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   output logic [ADDR_W-1:0] sp_o,
   output logic              ok_o,
   output logic              err_o
);

   logic [ADDR_W-1:0] sp_q;
   logic [ADDR_W-1:0] sp_d;
   logic              blocked;

`ifdef STACK_GUARD_EN
   logic err_q;
   logic err_d;

   assign blocked = (push_i && (sp_q == '0)) || (pop_i && (sp_q == SP_INIT));

   // Error flag is sticky until reset.
   always_comb begin
      err_d = err_q | blocked;
   end

   // Sticky guard error register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign err_o = err_q;
`else
   assign blocked = 1'b0;
   assign err_o   = 1'b0;
`endif

   // Next SP: push moves down, pop moves up, both modulo 2^ADDR_W.
   always_comb begin
      sp_d = sp_q;
      if (!blocked) begin
         if (push_i)     sp_d = sp_q - 1'b1;
         else if (pop_i) sp_d = sp_q + 1'b1;
      end
   end

   // Stack pointer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sp_q <= SP_INIT;
      else      sp_q <= sp_d;
   end

   assign sp_o = sp_q;
   assign ok_o = !blocked;

endmodule

// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl -- EX/MEM stage controller for load/store and a downward
// growing stack in data memory, including multi-cycle CALL/RET/INT/RTI.
// Optional macro STACK_GUARD_EN turns stack wrap into a sticky stack_err.
// Handshake: an op is accepted in a cycle where in_valid and in_ready are both
// high; in_ready is high only while idle, so multi-cycle ops stall the stage.
module stack_mem_ctrl
   import stack_mem_ctrl_pkg::*;
#(
   parameter int                ADDR_W  = ADDR_W_DEF,
   parameter int                DATA_W  = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] SP_INIT = SP_INIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              op_load,
   input  logic              op_store,
   input  logic              op_push,
   input  logic              op_pop,
   input  logic              op_call,
   input  logic              op_ret,
   input  logic              op_int,
   input  logic              op_rti,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] st_data,
   input  logic [31:0]       pc_in,
   input  logic [2:0]        ccr_in,
   input  logic [2:0]        rd_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [2:0]        wb_rd,
   output logic              pc_load,
   output logic [31:0]       pc_out,
   output logic              ccr_load,
   output logic [2:0]        ccr_out,
   output logic [ADDR_W-1:0] sp_out,
   output logic              stack_err,
   output logic [2:0]        dbg_state
);

   state_e            state_q, state_d;
   op_e               seq_q, seq_d;
   logic [15:0]       pc_lo_q, pc_lo_d;
   logic [2:0]        ccr_q, ccr_d;
   logic              wb_valid_q, wb_valid_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [2:0]        wb_rd_q, wb_rd_d;
   logic              pc_load_q, pc_load_d;
   logic [31:0]       pc_out_q, pc_out_d;
   logic              ccr_load_q, ccr_load_d;
   logic [2:0]        ccr_out_q, ccr_out_d;

   op_e               acc_op;
   logic              push_req;
   logic              pop_req;
   logic              store_we;
   logic              sp_ok;
   logic [ADDR_W-1:0] sp_cur;
   logic [ADDR_W-1:0] sp_inc;
   logic [15:0]       rd_half;
   logic [2:0]        rd_ccr;

   // Only an op presented while idle is taken; otherwise nothing is decoded.
   assign acc_op  = (in_valid && (state_q == ST_IDLE))
                  ? decode_op(op_int, op_rti, op_ret, op_call, op_pop, op_push, op_load, op_store)
                  : OP_NONE;
   assign sp_inc  = sp_cur + 1'b1;
   assign rd_half = 16'(mem_rdata);
   assign rd_ccr  = 3'(mem_rdata);

   stack_mem_ctrl_sp_unit #(
      .ADDR_W  (ADDR_W),
      .SP_INIT (SP_INIT)
   ) u_sp_unit (
      .clk    (clk),
      .rst    (rst),
      .push_i (push_req),
      .pop_i  (pop_req),
      .sp_o   (sp_cur),
      .ok_o   (sp_ok),
      .err_o  (stack_err)
   );

   // Memory port drive: address/data for this cycle and the stack request.
   // Kept free of mem_rdata so the external read path cannot loop back here.
   always_comb begin
      push_req  = 1'b0;
      pop_req   = 1'b0;
      store_we  = 1'b0;
      mem_addr  = sp_cur;
      mem_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            case (acc_op)
               OP_STORE: begin
                  mem_addr  = alu_addr;
                  mem_wdata = st_data;
                  store_we  = 1'b1;
               end
               OP_LOAD: mem_addr = alu_addr;
               OP_PUSH: begin
                  push_req  = 1'b1;
                  mem_wdata = st_data;
               end
               OP_POP, OP_RET, OP_RTI: begin
                  pop_req  = 1'b1;
                  mem_addr = sp_inc;
               end
               OP_CALL, OP_INT: begin
                  push_req  = 1'b1;
                  mem_wdata = DATA_W'(pc_in[31:16]);
               end
               default: ;
            endcase
         end
         ST_PUSH_LO: begin
            push_req  = 1'b1;
            mem_wdata = DATA_W'(pc_lo_q);
         end
         ST_PUSH_CCR: begin
            push_req  = 1'b1;
            mem_wdata = DATA_W'(ccr_q);
         end
         ST_POP_2, ST_POP_3: begin
            pop_req  = 1'b1;
            mem_addr = sp_inc;
         end
         default: ;
      endcase
   end

   // A blocked push (guard build) must not reach memory.
   assign mem_we = store_we | (push_req & sp_ok);

   // FSM next state, operand latching and registered result capture.
   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      pc_lo_d    = pc_lo_q;
      ccr_d      = ccr_q;
      wb_valid_d = 1'b0;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      pc_load_d  = 1'b0;
      pc_out_d   = pc_out_q;
      ccr_load_d = 1'b0;
      ccr_out_d  = ccr_out_q;
      case (state_q)
         ST_IDLE: begin
            case (acc_op)
               OP_LOAD, OP_POP: begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = mem_rdata;
                  wb_rd_d    = rd_in;
               end
               OP_CALL, OP_INT: begin
                  pc_lo_d = pc_in[15:0];
                  ccr_d   = ccr_in;
                  seq_d   = acc_op;
                  state_d = ST_PUSH_LO;
               end
               OP_RET: begin
                  pc_lo_d = rd_half;
                  seq_d   = OP_RET;
                  state_d = ST_POP_2;
               end
               OP_RTI: begin
                  ccr_d   = rd_ccr;
                  seq_d   = OP_RTI;
                  state_d = ST_POP_2;
               end
               default: ;
            endcase
         end
         ST_PUSH_LO: begin
            state_d = (seq_q == OP_INT) ? ST_PUSH_CCR : ST_IDLE;
         end
         ST_PUSH_CCR: begin
            state_d = ST_IDLE;
         end
         ST_POP_2: begin
            if (seq_q == OP_RTI) begin
               pc_lo_d = rd_half;
               state_d = ST_POP_3;
            end else begin
               pc_out_d  = {rd_half, pc_lo_q};
               pc_load_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_POP_3: begin
            pc_out_d   = {rd_half, pc_lo_q};
            pc_load_d  = 1'b1;
            ccr_out_d  = ccr_q;
            ccr_load_d = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, latched operands and output registers; reset aborts any sequence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         seq_q      <= OP_NONE;
         pc_lo_q    <= '0;
         ccr_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         pc_load_q  <= 1'b0;
         pc_out_q   <= '0;
         ccr_load_q <= 1'b0;
         ccr_out_q  <= '0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         pc_lo_q    <= pc_lo_d;
         ccr_q      <= ccr_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         pc_load_q  <= pc_load_d;
         pc_out_q   <= pc_out_d;
         ccr_load_q <= ccr_load_d;
         ccr_out_q  <= ccr_out_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign wb_valid  = wb_valid_q;
   assign wb_data   = wb_data_q;
   assign wb_rd     = wb_rd_q;
   assign pc_load   = pc_load_q;
   assign pc_out    = pc_out_q;
   assign ccr_load  = ccr_load_q;
   assign ccr_out   = ccr_out_q;
   assign sp_out    = sp_cur;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// tb_stack_mem_ctrl -- scoreboard bench for stack_mem_ctrl with a word-array
// data memory, a stack reference model and randomized op streams.
module tb_stack_mem_ctrl;

   localparam int             AW  = 12;
   localparam int             DW  = 16;
   localparam logic [AW-1:0]  SPI = 12'hFFF;
`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   // flag vector bit order = priority order
   localparam logic [7:0] F_INT = 8'h01, F_RTI = 8'h02, F_RET = 8'h04, F_CALL = 8'h08;
   localparam logic [7:0] F_POP = 8'h10, F_PUSH = 8'h20, F_LOAD = 8'h40, F_STORE = 8'h80;

   logic          clk, rst;
   logic          in_valid, in_ready;
   logic          op_load, op_store, op_push, op_pop, op_call, op_ret, op_int, op_rti;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] st_data;
   logic [31:0]   pc_in;
   logic [2:0]    ccr_in, rd_in;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_we;
   logic          wb_valid;
   logic [DW-1:0] wb_data;
   logic [2:0]    wb_rd;
   logic          pc_load, ccr_load, stack_err;
   logic [31:0]   pc_out;
   logic [2:0]    ccr_out;
   logic [AW-1:0] sp_out;
   logic [2:0]    dbg_state;

   logic [DW-1:0] env_mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic          env_clr;
   int            ref_sp;
   logic          ref_err;

   logic [AW+DW-1:0] exp_wr_q[$];
   logic [DW+2:0]    exp_wb_q[$];
   logic [35:0]      exp_pc_q[$];
   logic [AW+DW-1:0] mon_ew;
   logic [DW+2:0]    mon_eb;
   logic [35:0]      mon_ep;

   int total;
   int bad;

   stack_mem_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_load   (op_load),
      .op_store  (op_store),
      .op_push   (op_push),
      .op_pop    (op_pop),
      .op_call   (op_call),
      .op_ret    (op_ret),
      .op_int    (op_int),
      .op_rti    (op_rti),
      .alu_addr  (alu_addr),
      .st_data   (st_data),
      .pc_in     (pc_in),
      .ccr_in    (ccr_in),
      .rd_in     (rd_in),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .wb_valid  (wb_valid),
      .wb_data   (wb_data),
      .wb_rd     (wb_rd),
      .pc_load   (pc_load),
      .pc_out    (pc_out),
      .ccr_load  (ccr_load),
      .ccr_out   (ccr_out),
      .sp_out    (sp_out),
      .stack_err (stack_err),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // data memory: combinational read, synchronous write
   assign mem_rdata = env_mem[mem_addr];
   always @(posedge clk) begin
      if (env_clr) begin
         for (int i = 0; i < (1 << AW); i++) env_mem[i] <= 16'(i) ^ 16'h5A00;
      end else if (mem_we) begin
         env_mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // reference stack model
   task automatic m_push(input logic [15:0] d);
      if (GUARD && ref_sp == 0) begin
         ref_err = 1'b1;
      end else begin
         ref_mem[ref_sp] = d;
         exp_wr_q.push_back({AW'(ref_sp), d});
         ref_sp = (ref_sp - 1) & ((1 << AW) - 1);
      end
   endtask

   task automatic m_pop(output logic [15:0] v);
      int a;
      a = (ref_sp + 1) & ((1 << AW) - 1);
      v = ref_mem[a];
      if (GUARD && ref_sp == int'(SPI)) ref_err = 1'b1;
      else                              ref_sp = a;
   endtask

   // driver
   task automatic apply_flags(input logic [7:0] f);
      op_int = f[0]; op_rti = f[1]; op_ret = f[2]; op_call = f[3];
      op_pop = f[4]; op_push = f[5]; op_load = f[6]; op_store = f[7];
   endtask

   // called at posedge+1 with the DUT idle; returns at posedge+1 once idle again
   task automatic do_op(input logic [7:0] f, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [31:0] pc, input logic [2:0] ccr, input logic [2:0] rd);
      int k;
      int want_busy;
      int busy;
      logic [15:0] lo, hi, cw;
      k = 8;
      for (int i = 7; i >= 0; i--) if (f[i]) k = i;
      want_busy = 0;
      case (k)
         0: begin m_push(pc[31:16]); m_push(pc[15:0]); m_push({13'd0, ccr}); want_busy = 2; end
         1: begin
            m_pop(cw); m_pop(lo); m_pop(hi);
            exp_pc_q.push_back({1'b1, cw[2:0], hi, lo}); want_busy = 2;
         end
         2: begin m_pop(lo); m_pop(hi); exp_pc_q.push_back({4'b0, hi, lo}); want_busy = 1; end
         3: begin m_push(pc[31:16]); m_push(pc[15:0]); want_busy = 1; end
         4: begin m_pop(lo); exp_wb_q.push_back({rd, lo}); end
         5: m_push(d);
         6: exp_wb_q.push_back({rd, ref_mem[a]});
         7: begin ref_mem[a] = d; exp_wr_q.push_back({a, d}); end
         default: ;
      endcase
      chk("ready_at_issue", in_ready, 1);
      in_valid = 1'b1; apply_flags(f);
      alu_addr = a; st_data = d; pc_in = pc; ccr_in = ccr; rd_in = rd;
      @(posedge clk); #1;
      pc_in = $urandom; ccr_in = 3'($urandom_range(0, 7)); st_data = 16'($urandom);
      alu_addr = 12'($urandom); rd_in = 3'($urandom_range(0, 7));
      if (!in_ready) begin
         // a competing op while busy must be ignored
         in_valid = 1'b1; apply_flags(8'($urandom_range(1, 255)));
      end else begin
         in_valid = 1'b0; apply_flags(8'h00);
      end
      busy = 0;
      while (!in_ready && busy < 8) begin
         @(posedge clk); #1;
         busy++;
      end
      in_valid = 1'b0; apply_flags(8'h00);
      chk("busy_cycles", busy, want_busy);
      chk("sp_out", sp_out, ref_sp);
      chk("stack_err", stack_err, ref_err);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      ref_sp = int'(SPI); ref_err = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         if (mem_we) begin
            chk("wr_expected", exp_wr_q.size() != 0, 1);
            if (exp_wr_q.size() != 0) begin
               mon_ew = exp_wr_q.pop_front();
               chk("wr_addr", mem_addr, mon_ew[AW+DW-1:DW]);
               chk("wr_data", mem_wdata, mon_ew[DW-1:0]);
            end
         end
         if (wb_valid) begin
            chk("wb_expected", exp_wb_q.size() != 0, 1);
            if (exp_wb_q.size() != 0) begin
               mon_eb = exp_wb_q.pop_front();
               chk("wb_rd", wb_rd, mon_eb[DW+2:DW]);
               chk("wb_data", wb_data, mon_eb[DW-1:0]);
            end
         end
         if (pc_load || ccr_load) begin
            chk("pc_evt_expected", exp_pc_q.size() != 0, 1);
            if (exp_pc_q.size() != 0) begin
               mon_ep = exp_pc_q.pop_front();
               chk("pc_load", pc_load, 1);
               chk("ccr_load", ccr_load, mon_ep[35]);
               chk("pc_out", pc_out, mon_ep[31:0]);
               if (mon_ep[35]) chk("ccr_out", ccr_out, mon_ep[34:32]);
            end
         end
      end
   end

   // main sequence
   initial begin
      logic [7:0] f;
      int k;
      total = 0; bad = 0;
      rst = 1'b0; env_clr = 1'b1;
      in_valid = 1'b0; apply_flags(8'h00);
      alu_addr = '0; st_data = '0; pc_in = '0; ccr_in = '0; rd_in = '0;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 16'(i) ^ 16'h5A00;
      ref_sp = int'(SPI); ref_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      env_clr = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_sp_out", sp_out, SPI);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_pc_load", pc_load, 0);
      chk("rst_pc_out", pc_out, 0);
      chk("rst_ccr_load", ccr_load, 0);
      chk("rst_ccr_out", ccr_out, 0);
      chk("rst_stack_err", stack_err, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      do_op(F_PUSH, 12'h000, 16'hABCD, 32'h0, 3'd0, 3'd0);
      do_op(F_POP, 12'h000, 16'h0, 32'h0, 3'd0, 3'd1);
      do_op(F_CALL, 12'h000, 16'h0, 32'h0001_0203, 3'd0, 3'd0);
      do_op(F_RET, 12'h000, 16'h0, 32'h0, 3'd0, 3'd0);
      do_op(F_INT, 12'h000, 16'h0, 32'h0000_0050, 3'b101, 3'd0);
      do_op(F_RTI, 12'h000, 16'h0, 32'h0, 3'd0, 3'd0);
      do_op(F_INT | F_LOAD, 12'h010, 16'h0, 32'h1234_5678, 3'b011, 3'd2);
      do_op(F_RTI, 12'h000, 16'h0, 32'h0, 3'd0, 3'd0);
      do_op(F_STORE, 12'h010, 16'h1234, 32'h0, 3'd0, 3'd0);
      do_op(F_LOAD, 12'h010, 16'h0, 32'h0, 3'd0, 3'd3);
      do_op(8'h00, 12'h010, 16'h9999, 32'h0, 3'd0, 3'd0);
      // wrap boundary: pop at top, push at bottom
      do_op(F_POP, 12'h000, 16'h0, 32'h0, 3'd0, 3'd4);
      do_op(F_PUSH, 12'h000, 16'h7777, 32'h0, 3'd0, 3'd0);

      // reset during the second cycle of a CALL
      do_reset();
      chk("ready_at_issue", in_ready, 1);
      m_push(16'hDEAD);
      in_valid = 1'b1; apply_flags(F_CALL); pc_in = 32'hDEAD_BEEF; ccr_in = 3'd0;
      @(posedge clk); #1;
      in_valid = 1'b0; apply_flags(8'h00);
      chk("call_busy", in_ready, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      ref_sp = int'(SPI); ref_err = 1'b0;
      chk("abort_sp", sp_out, SPI);
      chk("abort_ready", in_ready, 1);
      do_op(F_LOAD, 12'hFFF, 16'h0, 32'h0, 3'd0, 3'd5);
      // pop straight out of reset (guard build flags it)
      do_op(F_POP, 12'h000, 16'h0, 32'h0, 3'd0, 3'd6);

      // randomized op stream with random lower-priority flags mixed in
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 8);
         f = 8'h00;
         if (k < 8) begin
            f[k] = 1'b1;
            for (int j = k + 1; j < 8; j++) f[j] = 1'($urandom_range(0, 1));
         end
         do_op(f, 12'($urandom_range(0, 31)), 16'($urandom), $urandom,
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("wr_q_drained", exp_wr_q.size(), 0);
      chk("wb_q_drained", exp_wb_q.size(), 0);
      chk("pc_q_drained", exp_pc_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
